tft_bus_arbiter: RTL and testbench
==================================

TFT_BUS_ARBITER -- requirements
Module: tft_bus_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, giving the number of requesters (index 0 = tft_init, index 1 = scene_exhibitor, index 2 = spare).
REQ-002 The block SHALL have parameter TIMEOUT, default 1023, giving the idle cycles allowed while granted before the grant is revoked; TIMEOUT=0 disables the watchdog.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1: reset, synchronous and active-low.
REQ-005 The block SHALL have port req, input, width NREQ: bit i high = requester i wants the SPI bus.
REQ-006 The block SHALL have port req_data, input, width 8*NREQ: requester i byte in bits [8i+7:8i].
REQ-007 The block SHALL have port req_dc, input, width NREQ: per-requester data/command flag.
REQ-008 The block SHALL have port req_transmit, input, width NREQ: per-requester transmit strobe.
REQ-009 The block SHALL have port grant, output, width NREQ: one-hot or zero; bit i = requester i owns the bus.
REQ-010 The block SHALL have port spi_busy, input, width 1: busy from tft_spi.
REQ-011 The block SHALL have ports spi_data (8), spi_dc (1) and spi_transmit (1), all outputs, driving the tft_spi inputs.
REQ-012 The block SHALL have port busy, output, width 1: high in any state other than IDLE.
REQ-013 The block SHALL have port timeout, output, width 1: one-cycle pulse when the watchdog revokes a grant.

Function
REQ-014 The state machine SHALL have exactly three states: IDLE, GRANT, DRAIN.
REQ-015 In IDLE with any req bit high, the block SHALL select the winner by round-robin starting at index ptr, enter GRANT, and assert that grant bit on the next cycle, giving one-cycle request-to-grant latency.
REQ-016 In IDLE with req all zero, the block SHALL remain in IDLE with grant=0.
REQ-017 Requests that change during GRANT or DRAIN SHALL NOT alter the current grant.
REQ-018 In GRANT, spi_data, spi_dc and spi_transmit SHALL combinationally equal the granted requester's slice.
REQ-019 Outside GRANT, spi_data, spi_dc and spi_transmit SHALL all be 0.
REQ-020 req_transmit from non-granted requesters SHALL never reach spi_transmit.
REQ-021 In GRANT, when req of the granted index goes low, the block SHALL drop grant on the next cycle and enter DRAIN.
REQ-022 In DRAIN, the block SHALL remain there while spi_busy=1 and enter IDLE on the first cycle spi_busy=0; the bus SHALL NOT be handed over mid-byte.
REQ-023 On leaving GRANT by either release or timeout, ptr SHALL become (granted index + 1) mod NREQ.
REQ-024 Watchdog operation in GRANT:
  - counter increments on each cycle with spi_busy=0 and the granted req_transmit=0;
  - counter clears on any transmit or while spi_busy=1;
  - counter clears on entering GRANT;
  - counter is width ceil(log2(TIMEOUT+1)) and saturates, never wrapping.
REQ-025 When the counter reaches TIMEOUT, the block SHALL enter DRAIN, drop grant and pulse timeout for one cycle.
REQ-026 If release and timeout occur in the same cycle, release SHALL take precedence and timeout SHALL NOT pulse.
REQ-027 A revoked requester that still holds req high SHALL be eligible again only after ptr has advanced past it, with no starvation of other requesters.
REQ-028 Simultaneous requests SHALL be resolved by ptr order only, with no fixed priority beyond the reset value of ptr.

Reset
REQ-029 With rst=0 at a clock edge, the block SHALL set: state IDLE, grant=0, ptr=0, counter=0, busy=0, timeout=0, spi_transmit=0, spi_data=0, spi_dc=0.
REQ-030 Reset asserted mid-byte (GRANT or DRAIN) SHALL abort immediately with no drain; the tft_spi instance is reset by the same rst.
REQ-031 After reset release, requester 0 SHALL win any simultaneous request, so initialisation precedes scene drawing.

Verification
REQ-032 The bench SHALL cover: reset release, then req=3'b011 at cycle 0 -> grant=3'b001 at cycle 1; after req[0] falls and spi_busy=0, grant=3'b010 two cycles later.
REQ-033 The bench SHALL cover: requester 1 granted with req_transmit[1]=1, req_data[15:8]=8'hA5, req_dc[1]=1 -> spi_transmit=1, spi_data=8'hA5, spi_dc=1 in the same cycle; req_transmit[0]=1 at the same time has no effect.
REQ-034 The bench SHALL cover: release while spi_busy=1 for 16 cycles -> grant=0, busy=1 for those 16 cycles; IDLE and the new grant follow only after spi_busy falls.
REQ-035 The bench SHALL cover: TIMEOUT=8 with the granted requester idle -> after 8 idle cycles timeout pulses once, grant drops, and ptr advances so a waiting requester 2 is granted next.
REQ-036 The bench SHALL cover: all three requesting continuously, each releasing after one byte -> grant sequence 001, 010, 100, 001.
REQ-037 The bench SHALL cover: rst=0 asserted during GRANT with spi_transmit=1 -> next cycle grant=0, spi_transmit=0, busy=0, ptr=0.

Source files
------------

// File: rtl/tft_bus_arbiter.sv
// Round-robin arbiter that shares one tft_spi byte engine between several
// requesters. The owner's byte, D/C flag and transmit strobe are muxed
// straight through while it holds the grant. After a release or a revoke the
// bus drains the in-flight byte before anyone else is granted. A watchdog
// revokes a grant that sits idle for too long.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | bus free, round-robin pick from ptr on any request
// S_GRANT | one requester owns the bus, its slice drives tft_spi
// S_DRAIN | grant dropped, waiting for tft_spi to finish the current byte
module tft_bus_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_dc,
  input  logic [NREQ-1:0]   req_transmit,
  output logic [NREQ-1:0]   grant,
  input  logic              spi_busy,
  output logic [7:0]        spi_data,
  output logic              spi_dc,
  output logic              spi_transmit,
  output logic              busy,
  output logic              timeout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_TO  = CW'(TIMEOUT);
  localparam bit WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q;
  logic [NREQ-1:0] grant_q;
  logic [IW-1:0]   gidx_q;
  logic [IW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            timeout_q;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic            owner_req;
  logic            owner_tx;
  logic            wd_fire;
  logic [IW-1:0]   ptr_next;

  // Round-robin winner: first requesting index at or after ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!win_found && req[i] && (((int'(ptr_q) + k) % NREQ) == i)) begin
          win_found = 1'b1;
          win_idx   = IW'(i);
        end
      end
    end
  end

  assign owner_req = |(req & grant_q);
  assign owner_tx  = |(req_transmit & grant_q);
  assign ptr_next  = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;

  // Watchdog count for the next cycle: idle cycles accumulate and saturate,
  // any transmit or busy byte engine clears it.
  always_comb begin
    cnt_d = '0;
    if (!spi_busy && !owner_tx) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  assign wd_fire = WD_EN && (cnt_d == CNT_TO);

  // Arbitration FSM with registered grant and timeout pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            state_q <= S_GRANT;
            grant_q <= NREQ'(1) << win_idx;
            gidx_q  <= win_idx;
            cnt_q   <= '0;
          end
        end
        S_GRANT: begin
          cnt_q <= cnt_d;
          // Release wins over a same-cycle watchdog expiry.
          if (!owner_req) begin
            state_q <= S_DRAIN;
            grant_q <= '0;
            ptr_q   <= ptr_next;
          end else if (wd_fire) begin
            state_q   <= S_DRAIN;
            grant_q   <= '0;
            ptr_q     <= ptr_next;
            timeout_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (!spi_busy) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // Pass the owner's slice to tft_spi only while in GRANT; zero otherwise.
  always_comb begin
    spi_data     = '0;
    spi_dc       = 1'b0;
    spi_transmit = 1'b0;
    if (state_q == S_GRANT) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_q[i]) begin
          spi_data     = req_data[8*i +: 8];
          spi_dc       = req_dc[i];
          spi_transmit = req_transmit[i];
        end
      end
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q != S_IDLE);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_tft_bus_arbiter.sv
// Bench for tft_bus_arbiter: a vector table, hand-written multi-cycle
// sequences, then random stimulus checked against a behavioural model.
module tb_tft_bus_arbiter;

  localparam int TMO = 8;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [23:0] req_data;
  logic [2:0]  req_dc;
  logic [2:0]  req_transmit;
  logic [2:0]  grant;
  logic        spi_busy;
  logic [7:0]  spi_data;
  logic        spi_dc;
  logic        spi_transmit;
  logic        busy;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  // behavioural model: who owns the bus, whether a byte is draining
  int m_owner = -1;
  int m_ptr   = 0;
  int m_idle  = 0;
  bit m_drain = 1'b0;
  bit m_to    = 1'b0;

  tft_bus_arbiter #(.NREQ(3), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .req_dc       (req_dc),
    .req_transmit (req_transmit),
    .grant        (grant),
    .spi_busy     (spi_busy),
    .spi_data     (spi_data),
    .spi_dc       (spi_dc),
    .spi_transmit (spi_transmit),
    .busy         (busy),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_v;
    logic [2:0]  req_v;
    logic [2:0]  tx_v;
    logic        sb_v;
    logic [2:0]  e_grant;
    logic        e_busy;
    logic        e_to;
    logic        e_tx;
    logic [7:0]  e_data;
    logic        e_dc;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    m_to = 1'b0;
    if (!rst) begin
      m_owner = -1;
      m_drain = 1'b0;
      m_ptr   = 0;
      m_idle  = 0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_ptr   = (m_owner + 1) % 3;
        m_owner = -1;
        m_drain = 1'b1;
      end else begin
        if (spi_busy || req_transmit[m_owner]) m_idle = 0;
        else m_idle++;
        if (m_idle >= TMO) begin
          m_ptr   = (m_owner + 1) % 3;
          m_owner = -1;
          m_drain = 1'b1;
          m_to    = 1'b1;
        end
      end
    end else if (m_drain) begin
      if (!spi_busy) m_drain = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        int i;
        i = (m_ptr + k) % 3;
        if (m_owner < 0 && req[i]) begin
          m_owner = i;
          m_idle  = 0;
        end
      end
    end
  endtask

  task automatic clock();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model(input int cyc);
    logic [2:0] eg;
    logic [7:0] ed;
    logic       edc;
    logic       etx;
    eg = 3'b000; ed = 8'h00; edc = 1'b0; etx = 1'b0;
    if (m_owner >= 0) begin
      eg  = 3'(1 << m_owner);
      ed  = req_data[8*m_owner +: 8];
      edc = req_dc[m_owner];
      etx = req_transmit[m_owner];
    end
    chk($sformatf("rand%0d grant", cyc), 32'(grant), 32'(eg));
    chk($sformatf("rand%0d busy", cyc), 32'(busy), 32'(m_owner >= 0 || m_drain));
    chk($sformatf("rand%0d timeout", cyc), 32'(timeout), 32'(m_to));
    chk($sformatf("rand%0d spi_data", cyc), 32'(spi_data), 32'(ed));
    chk($sformatf("rand%0d spi_dc", cyc), 32'(spi_dc), 32'(edc));
    chk($sformatf("rand%0d spi_tx", cyc), 32'(spi_transmit), 32'(etx));
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; req_transmit = '0; spi_busy = 1'b0;
    clock();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; req = '0; req_data = 24'h00_A5_3C; req_dc = 3'b010;
    req_transmit = '0; spi_busy = 1'b0;

    // rst req tx sb | grant busy to tx data dc
    vecs[0] = '{1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 3'b011, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0};
    vecs[2] = '{1'b1, 3'b010, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 3'b010, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 3'b010, 3'b011, 1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1};
    vecs[5] = '{1'b1, 3'b010, 3'b001, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1};
    vecs[6] = '{1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{1'b1, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

    for (int v = 0; v < 8; v++) begin
      rst = vecs[v].rst_v; req = vecs[v].req_v;
      req_transmit = vecs[v].tx_v; spi_busy = vecs[v].sb_v;
      clock();
      chk($sformatf("vec%0d grant", v), 32'(grant), 32'(vecs[v].e_grant));
      chk($sformatf("vec%0d busy", v), 32'(busy), 32'(vecs[v].e_busy));
      chk($sformatf("vec%0d timeout", v), 32'(timeout), 32'(vecs[v].e_to));
      chk($sformatf("vec%0d spi_tx", v), 32'(spi_transmit), 32'(vecs[v].e_tx));
      chk($sformatf("vec%0d spi_data", v), 32'(spi_data), 32'(vecs[v].e_data));
      chk($sformatf("vec%0d spi_dc", v), 32'(spi_dc), 32'(vecs[v].e_dc));
    end

    // release while the byte engine stays busy for 16 cycles
    do_reset();
    req = 3'b001;
    clock();
    chk("drain16 first grant", 32'(grant), 32'(3'b001));
    req = 3'b010; spi_busy = 1'b1;
    for (int c = 0; c < 16; c++) begin
      clock();
      chk($sformatf("drain16 c%0d grant", c), 32'(grant), 32'(3'b000));
      chk($sformatf("drain16 c%0d busy", c), 32'(busy), 32'(1'b1));
    end
    spi_busy = 1'b0;
    clock();
    chk("drain16 idle busy", 32'(busy), 32'(1'b0));
    chk("drain16 idle grant", 32'(grant), 32'(3'b000));
    clock();
    chk("drain16 next grant", 32'(grant), 32'(3'b010));

    // watchdog revokes an idle owner after 8 idle cycles
    do_reset();
    req = 3'b101;
    clock();
    chk("wd grant0", 32'(grant), 32'(3'b001));
    for (int c = 1; c < TMO; c++) begin
      clock();
      chk($sformatf("wd hold%0d grant", c), 32'(grant), 32'(3'b001));
      chk($sformatf("wd hold%0d timeout", c), 32'(timeout), 32'(1'b0));
    end
    clock();
    chk("wd fire grant", 32'(grant), 32'(3'b000));
    chk("wd fire timeout", 32'(timeout), 32'(1'b1));
    chk("wd fire busy", 32'(busy), 32'(1'b1));
    clock();
    chk("wd pulse end", 32'(timeout), 32'(1'b0));
    chk("wd idle busy", 32'(busy), 32'(1'b0));
    clock();
    chk("wd next grant", 32'(grant), 32'(3'b100));
    req = 3'b001;
    clock(); clock(); clock();
    chk("wd revoked regrant", 32'(grant), 32'(3'b001));

    // three continuous requesters, each releasing after one byte
    do_reset();
    req = 3'b111;
    clock();
    begin
      logic [2:0] seq [4];
      seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
      for (int s = 0; s < 4; s++) begin
        chk($sformatf("rr step%0d grant", s), 32'(grant), 32'(seq[s]));
        req_transmit = seq[s];
        #1;
        chk($sformatf("rr step%0d spi_tx", s), 32'(spi_transmit), 32'(1'b1));
        clock();
        req_transmit = 3'b000;
        req = 3'b111 & ~seq[s];
        clock();
        req = 3'b111;
        clock();
        clock();
      end
    end

    // reset in the middle of a byte
    do_reset();
    req = 3'b010;
    clock();
    chk("rstmid grant", 32'(grant), 32'(3'b010));
    req_transmit = 3'b010;
    #1;
    chk("rstmid spi_tx before", 32'(spi_transmit), 32'(1'b1));
    rst = 1'b0;
    clock();
    chk("rstmid grant after", 32'(grant), 32'(3'b000));
    chk("rstmid spi_tx after", 32'(spi_transmit), 32'(1'b0));
    chk("rstmid busy after", 32'(busy), 32'(1'b0));
    chk("rstmid spi_data after", 32'(spi_data), 32'(8'h00));
    rst = 1'b1; req = 3'b111; req_transmit = 3'b000;
    clock();
    chk("rstmid ptr zero", 32'(grant), 32'(3'b001));

    // random stimulus against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      end
      if ($urandom_range(0, 3) == 0) spi_busy = ~spi_busy;
      req_transmit = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7))
                     & 3'($urandom_range(0, 7));
      req_data = 24'($urandom);
      req_dc   = 3'($urandom_range(0, 7));
      rst      = ($urandom_range(0, 299) != 0);
      clock();
      check_model(c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
